// File: rtl/stepper_axis.sv
// Single-axis step/dir pulse generator with linear accel/decel ramp, limit blocking, abort and homing.
// Latency: accepted start edge shows step=1/busy=1 one cycle later; limit/abort stop the move the cycle after sampling.
module stepper_axis #(
    parameter int STEP_W = 32,
    parameter int PER_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              home_i,
    input  logic [STEP_W-1:0] step_in_i,
    input  logic [PER_W-1:0]  start_per_i,
    input  logic [PER_W-1:0]  target_per_i,
    input  logic [PER_W-1:0]  accel_dec_i,
    input  logic              lim_min_i,
    input  logic              lim_max_i,
    output logic              step_o,
    output logic              dir_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              lim_hit_o,
    output logic [STEP_W-1:0] remaining_o
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [STEP_W-1:0] MOST_NEG = {1'b1, {(STEP_W-1){1'b0}}};
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-2:0] MAG_ONE  = {{(STEP_W-2){1'b0}}, 1'b1};
    localparam logic [PER_W-1:0]  PER_ONE  = {{(PER_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              step_q, step_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lim_hit_q, lim_hit_d;
    logic              home_q, home_d;
    logic              start_prev_q;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [STEP_W-2:0] ramp_q, ramp_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [PER_W-1:0]  timer_q, timer_d;
    logic [PER_W-1:0]  sp_q, sp_d;
    logic [PER_W-1:0]  tp_q, tp_d;
    logic [PER_W-1:0]  accel_q, accel_d;

    logic [PER_W-1:0]  sp_raw, sp_eff, tp_eff;
    logic [PER_W-1:0]  gap_dn, gap_up, per_dn, per_up, per_next;
    logic [STEP_W-2:0] rem_mag;
    logic [STEP_W-1:0] rem_step;
    logic              start_edge, new_dir, blocked_now, travel_blocked, terminate, accelerate;

    assign sp_raw = (start_per_i == '0) ? PER_ONE : start_per_i;
    assign tp_eff = (target_per_i == '0) ? PER_ONE : target_per_i;
    assign sp_eff = (sp_raw < tp_eff) ? tp_eff : sp_raw;

    assign start_edge     = start_i & ~start_prev_q;
    assign new_dir        = home_i | step_in_i[STEP_W-1];
    assign blocked_now    = new_dir ? lim_min_i : lim_max_i;
    assign travel_blocked = dir_q ? lim_min_i : lim_max_i;
    assign terminate      = abort_i | travel_blocked;

    // remaining never holds the most negative value, so the magnitude fits STEP_W-1 bits
    assign rem_mag  = remaining_q[STEP_W-1] ? (~remaining_q[STEP_W-2:0] + MAG_ONE)
                                            : remaining_q[STEP_W-2:0];
    assign rem_step = remaining_q[STEP_W-1] ? (remaining_q + STEP_ONE) : (remaining_q - STEP_ONE);

    // period always lies in [tp_q, sp_q], so both gaps are non-negative
    assign gap_dn     = period_q - tp_q;
    assign gap_up     = sp_q - period_q;
    assign per_dn     = (accel_q < gap_dn) ? (period_q - accel_q) : tp_q;
    assign per_up     = (accel_q < gap_up) ? (period_q + accel_q) : sp_q;
    assign accelerate = home_q | (rem_mag > ramp_q);
    assign per_next   = accelerate ? per_dn : per_up;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        dir_d       = dir_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        lim_hit_d   = lim_hit_q;
        home_d      = home_q;
        remaining_d = remaining_q;
        ramp_d      = ramp_q;
        period_d    = period_q;
        timer_d     = timer_q;
        sp_d        = sp_q;
        tp_d        = tp_q;
        accel_d     = accel_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    if (abort_i) begin
                        done_d = 1'b1;
                    end else if (!home_i && ((step_in_i == '0) || (step_in_i == MOST_NEG))) begin
                        done_d = 1'b1;
                    end else if (blocked_now) begin
                        done_d    = 1'b1;
                        lim_hit_d = 1'b1;
                    end else begin
                        state_d     = HIGH;
                        step_d      = 1'b1;
                        busy_d      = 1'b1;
                        dir_d       = new_dir;
                        home_d      = home_i;
                        remaining_d = home_i ? '0 : step_in_i;
                        lim_hit_d   = 1'b0;
                        ramp_d      = '0;
                        period_d    = sp_eff;
                        timer_d     = sp_eff - PER_ONE;
                        sp_d        = sp_eff;
                        tp_d        = tp_eff;
                        accel_d     = accel_dec_i;
                    end
                end
            end
            HIGH, LOW: begin
                if (terminate) begin
                    state_d = IDLE;
                    step_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (travel_blocked) begin
                        lim_hit_d = 1'b1;
                    end
                    // a pulse cut short while high still reached the driver
                    if (home_q) begin
                        remaining_d = '0;
                    end else if (state_q == HIGH) begin
                        remaining_d = rem_step;
                    end
                end else if (timer_q != '0) begin
                    timer_d = timer_q - PER_ONE;
                end else if (state_q == HIGH) begin
                    state_d = LOW;
                    step_d  = 1'b0;
                    timer_d = period_q - PER_ONE;
                    if (!home_q) begin
                        remaining_d = rem_step;
                    end
                end else if ((remaining_q != '0) || home_q) begin
                    state_d  = HIGH;
                    step_d   = 1'b1;
                    period_d = per_next;
                    timer_d  = per_next - PER_ONE;
                    if (!home_q) begin
                        if (accelerate) begin
                            if (per_dn != period_q) begin
                                ramp_d = ramp_q + MAG_ONE;
                            end
                        end else if (ramp_q != '0) begin
                            ramp_d = ramp_q - MAG_ONE;
                        end
                    end
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lim_hit_q    <= 1'b0;
            home_q       <= 1'b0;
            start_prev_q <= 1'b0;
            remaining_q  <= '0;
            ramp_q       <= '0;
            period_q     <= '0;
            timer_q      <= '0;
            sp_q         <= '0;
            tp_q         <= '0;
            accel_q      <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            lim_hit_q    <= lim_hit_d;
            home_q       <= home_d;
            start_prev_q <= start_i;
            remaining_q  <= remaining_d;
            ramp_q       <= ramp_d;
            period_q     <= period_d;
            timer_q      <= timer_d;
            sp_q         <= sp_d;
            tp_q         <= tp_d;
            accel_q      <= accel_d;
        end
    end

    assign step_o      = step_q;
    assign dir_o       = dir_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign lim_hit_o   = lim_hit_q;
    assign remaining_o = remaining_q;

endmodule

// File: tb/tb_stepper_axis.sv
// Directed bench for stepper_axis: pulse widths are scoreboarded against queued expectations.
module tb_stepper_axis;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, home = 1'b0;
    logic [31:0] step_in = '0, start_per = '0, target_per = '0, accel_dec = '0;
    logic        lim_min = 1'b0, lim_max = 1'b0;
    logic        step, dir, busy, done, lim_hit;
    logic [31:0] remaining;

    int checks = 0;
    int failures = 0;
    int exp_hi[$];
    int exp_lo[$];
    bit sb_en = 1'b0;
    int pulse_cnt = 0;
    int hi_cnt = 0, lo_cnt = 0;
    logic step_prev = 1'b0;
    int cyc;

    stepper_axis #(.STEP_W(32), .PER_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .home_i(home),
        .step_in_i(step_in), .start_per_i(start_per), .target_per_i(target_per),
        .accel_dec_i(accel_dec), .lim_min_i(lim_min), .lim_max_i(lim_max),
        .step_o(step), .dir_o(dir), .busy_o(busy), .done_o(done), .lim_hit_o(lim_hit),
        .remaining_o(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic sb_hi(input int got);
        int e;
        e = (exp_hi.size() > 0) ? exp_hi.pop_front() : -1;
        chk("high_width", 64'(got), 64'(e));
    endtask

    task automatic sb_lo(input int got);
        int e;
        e = (exp_lo.size() > 0) ? exp_lo.pop_front() : -1;
        chk("low_width", 64'(got), 64'(e));
    endtask

    // Pulse monitor: sampled on the falling clock edge
    always @(negedge clk) begin
        if (step && !step_prev) pulse_cnt++;
        if (sb_en) begin
            if (step) hi_cnt++;
            else if (hi_cnt > 0) begin sb_hi(hi_cnt); hi_cnt = 0; end
            if (busy && !step) lo_cnt++;
            else if (lo_cnt > 0) begin sb_lo(lo_cnt); lo_cnt = 0; end
        end else begin
            hi_cnt = 0;
            lo_cnt = 0;
        end
        step_prev = step;
    end

    // Drives a start edge; returns at the falling edge one cycle after it was sampled.
    task automatic do_start(input logic hm, input logic [31:0] si, input logic [31:0] sp,
                            input logic [31:0] tp, input logic [31:0] ac, input logic keep);
        @(negedge clk);
        home = hm; step_in = si; start_per = sp; target_per = tp; accel_dec = ac;
        start = 1'b1;
        @(negedge clk);
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic push_both(input int w);
        exp_hi.push_back(w);
        exp_lo.push_back(w);
    endtask

    task automatic sb_drain(input string tag);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_hi_left"}, 64'(exp_hi.size()), 64'd0);
        chk({tag, "_lo_left"}, 64'(exp_lo.size()), 64'd0);
        sb_en = 1'b0;
    endtask

    initial begin
        int ramp_w[10];
        ramp_w = '{8, 6, 4, 2, 2, 2, 2, 4, 6, 8};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_step", 64'(step), 64'd0);
        chk("rst_dir", 64'(dir), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lim_hit", 64'(lim_hit), 64'd0);
        chk("rst_remaining", 64'(remaining), 64'd0);
        rst = 1'b0;

        // Five constant pulses, 3 high / 3 low
        sb_en = 1'b1;
        for (int i = 0; i < 5; i++) push_both(3);
        pulse_cnt = 0;
        do_start(1'b0, 32'd5, 32'd3, 32'd3, 32'd0, 1'b0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_step", 64'(step), 64'd1);
        chk("t1_dir", 64'(dir), 64'd0);
        chk("t1_rem_start", 64'(remaining), 64'd5);
        repeat (3) @(negedge clk);
        chk("t1_rem_after_fall", 64'(remaining), 64'd4);
        cyc = 3;
        begin
            int n;
            wait_done(200, n);
            cyc += n;
        end
        chk("t1_done_cycle", 64'(cyc), 64'd30);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_rem_end", 64'(remaining), 64'd0);
        chk("t1_pulses", 64'(pulse_cnt), 64'd5);
        sb_drain("t1");

        // Limit already asserted in the move direction
        lim_min = 1'b1;
        do_start(1'b0, -32'sd4, 32'd3, 32'd3, 32'd0, 1'b0);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_step", 64'(step), 64'd0);
        chk("t2_lim_hit", 64'(lim_hit), 64'd1);
        lim_min = 1'b0;

        // Symmetric ramp profile
        sb_en = 1'b1;
        foreach (ramp_w[i]) push_both(ramp_w[i]);
        pulse_cnt = 0;
        do_start(1'b0, 32'd10, 32'd8, 32'd2, 32'd2, 1'b0);
        chk("t3_lim_hit_cleared", 64'(lim_hit), 64'd0);
        wait_done(400, cyc);
        chk("t3_done_cycle", 64'(cyc), 64'd88);
        chk("t3_rem_end", 64'(remaining), 64'd0);
        chk("t3_pulses", 64'(pulse_cnt), 64'd10);
        sb_drain("t3");

        // lim_max during 3rd high phase; lim_min toggles are ignored moving positive
        pulse_cnt = 0;
        do_start(1'b0, 32'd100, 32'd3, 32'd3, 32'd0, 1'b0);
        repeat (2) @(negedge clk); lim_min = 1'b1;
        repeat (3) @(negedge clk); lim_min = 1'b0;
        repeat (2) @(negedge clk); lim_min = 1'b1;
        repeat (3) @(negedge clk); lim_min = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_busy_mid", 64'(busy), 64'd1);
        chk("t4_step_mid", 64'(step), 64'd1);
        chk("t4_rem_mid", 64'(remaining), 64'd98);
        lim_max = 1'b1;
        @(negedge clk);
        chk("t4_step", 64'(step), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_rem", 64'(remaining), 64'd97);
        chk("t4_lim_hit", 64'(lim_hit), 64'd1);
        chk("t4_pulses", 64'(pulse_cnt), 64'd3);
        lim_max = 1'b0;

        // Homing until lim_min after 7 pulses
        pulse_cnt = 0;
        do_start(1'b1, 32'd0, 32'd2, 32'd2, 32'd0, 1'b0);
        chk("t5_dir", 64'(dir), 64'd1);
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_lim_hit_cleared", 64'(lim_hit), 64'd0);
        cyc = 0;
        while (!(pulse_cnt == 7 && !step) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_seven_pulses", 64'(pulse_cnt), 64'd7);
        lim_min = 1'b1;
        @(negedge clk);
        chk("t5_busy_end", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_dir_end", 64'(dir), 64'd1);
        chk("t5_rem", 64'(remaining), 64'd0);
        chk("t5_lim_hit", 64'(lim_hit), 64'd1);
        chk("t5_pulses", 64'(pulse_cnt), 64'd7);
        lim_min = 1'b0;
        home = 1'b0;

        // Reset in the middle of a high phase
        do_start(1'b0, 32'd3, 32'd4, 32'd4, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_step_async", 64'(step), 64'd0);
        chk("t6_busy_async", 64'(busy), 64'd0);
        chk("t6_rem_async", 64'(remaining), 64'd0);
        @(negedge clk);
        chk("t6_no_done", 64'(done), 64'd0);
        rst = 1'b0;
        sb_en = 1'b1;
        push_both(2);
        pulse_cnt = 0;
        do_start(1'b0, 32'd1, 32'd2, 32'd2, 32'd0, 1'b0);
        wait_done(100, cyc);
        chk("t6_done_cycle", 64'(cyc), 64'd4);
        chk("t6_pulses", 64'(pulse_cnt), 64'd1);
        sb_drain("t6");

        // Abort and start together: rejected with done
        abort = 1'b1;
        do_start(1'b0, 32'd5, 32'd3, 32'd3, 32'd0, 1'b0);
        chk("t7_done", 64'(done), 64'd1);
        chk("t7_busy", 64'(busy), 64'd0);
        abort = 1'b0;

        // Abort during a high phase
        do_start(1'b0, 32'd5, 32'd3, 32'd3, 32'd0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        chk("t8_busy", 64'(busy), 64'd0);
        chk("t8_done", 64'(done), 64'd1);
        chk("t8_rem", 64'(remaining), 64'd4);
        chk("t8_lim_hit", 64'(lim_hit), 64'd0);
        abort = 1'b0;

        // Zero and most-negative step counts are rejected
        do_start(1'b0, 32'd0, 32'd3, 32'd3, 32'd0, 1'b0);
        chk("t9_zero_done", 64'(done), 64'd1);
        chk("t9_zero_busy", 64'(busy), 64'd0);
        do_start(1'b0, 32'h8000_0000, 32'd3, 32'd3, 32'd0, 1'b0);
        chk("t9_min_done", 64'(done), 64'd1);
        chk("t9_min_busy", 64'(busy), 64'd0);

        // Zero periods run at 1 cycle; held start launches nothing more
        sb_en = 1'b1;
        push_both(1);
        pulse_cnt = 0;
        do_start(1'b0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1);
        wait_done(50, cyc);
        chk("t10_done_cycle", 64'(cyc), 64'd2);
        sb_drain("t10");
        repeat (5) @(negedge clk);
        chk("t10_held_busy", 64'(busy), 64'd0);
        chk("t10_held_pulses", 64'(pulse_cnt), 64'd1);
        start = 1'b0;

        // start_per below target_per is raised to target_per; opposite limit ignored
        sb_en = 1'b1;
        push_both(3);
        push_both(3);
        lim_min = 1'b1;
        do_start(1'b0, 32'd2, 32'd1, 32'd3, 32'd1, 1'b0);
        chk("t11_busy", 64'(busy), 64'd1);
        wait_done(100, cyc);
        chk("t11_done_cycle", 64'(cyc), 64'd12);
        chk("t11_lim_hit", 64'(lim_hit), 64'd0);
        sb_drain("t11");
        lim_min = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
